// File: rtl/spi_slave_sync_if.sv
// Local-IP side of the SPI responder: transmit load, receive read, status and FSM debug.
// Handshake: a byte moves on ld only in a cycle where tx_ready=1; rd acknowledges dout whenever rx_full=1.
interface spi_slave_sync_if;
  logic [7:0] din;
  logic       ld;
  logic       tx_ready;
  logic [7:0] dout;
  logic       rx_full;
  logic       rd;
  logic       overrun;
  logic       busy;
  logic       state_dbg;

  // master = the local IP driving the buffers; slave = the SPI responder.
  modport master (
    output din, ld, rd,
    input  tx_ready, dout, rx_full, overrun, busy, state_dbg
  );

  modport slave (
    input  din, ld, rd,
    output tx_ready, dout, rx_full, overrun, busy, state_dbg
  );
endinterface

// File: rtl/spi_slave_sync.sv
// Mode-0, MSB-first, 8-bit SPI responder that oversamples sclk/cs_n/mosi in the mclk domain.
// Exposes a one-byte transmit buffer and a one-byte receive register to the local IP.
module spi_slave_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            mclk,
  input  logic            rst,
  input  logic            sclk_in,
  input  logic            cs_n_in,
  input  logic            mosi_in,
  output logic            miso,
  output logic            miso_oe,
  spi_slave_sync_if.slave ip
);

  generate
    if (WIDTH != 8) begin : g_bad_width
      $error("spi_slave_sync: WIDTH must be 8");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("spi_slave_sync: SYNC_STAGES must be at least 2");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   cs_dly_q;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;

  always_ff @(posedge mclk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  // Only the first seven bits need storing; the eighth is merged straight into dout.
  logic [6:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  txbuf_q, txbuf_d;
  logic        txvalid_q, txvalid_d;
  logic [7:0]  dout_q, dout_d;
  logic        rx_full_q, rx_full_d;
  logic        overrun_q, overrun_d;

  logic        take;
  logic        complete;
  logic        accept;
  logic [7:0]  load_byte;

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      txbuf_q    <= '0;
      txvalid_q  <= 1'b0;
      dout_q     <= '0;
      rx_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      txbuf_q    <= txbuf_d;
      txvalid_q  <= txvalid_d;
      dout_q     <= dout_d;
      rx_full_q  <= rx_full_d;
      overrun_q  <= overrun_d;
    end
  end

  assign load_byte = txvalid_q ? txbuf_q : 8'h00;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    take       = 1'b0;
    complete   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d    = ST_SHIFT;
          take       = 1'b1;
          tx_shift_d = load_byte;
          bit_cnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        // Deselect beats any simultaneous sclk edge; a partial byte is dropped.
        if (cs_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          complete   = (bit_cnt_q == 4'd7);
        end else if (sclk_fall) begin
          if (bit_cnt_q == 4'd8) begin
            take       = 1'b1;
            tx_shift_d = load_byte;
            bit_cnt_d  = '0;
          end else if (bit_cnt_q != 4'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A transfer always takes the old buffer contents, so a coincident ld still lands.
  assign accept = ip.ld & ~txvalid_q;

  always_comb begin
    txbuf_d   = txbuf_q;
    txvalid_d = txvalid_q;
    if (accept) begin
      txbuf_d   = ip.din;
      txvalid_d = 1'b1;
    end else if (take) begin
      txvalid_d = 1'b0;
    end
  end

  always_comb begin
    dout_d    = dout_q;
    rx_full_d = rx_full_q;
    overrun_d = overrun_q;
    if (complete) begin
      dout_d    = {rx_shift_q, mosi_s};
      rx_full_d = 1'b1;
      overrun_d = ip.rd ? 1'b0 : (overrun_q | rx_full_q);
    end else if (ip.rd) begin
      rx_full_d = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign miso         = (state_q == ST_SHIFT) ? tx_shift_q[7] : 1'b0;
  assign miso_oe      = (state_q == ST_SHIFT);
  assign ip.busy      = (state_q == ST_SHIFT);
  assign ip.state_dbg = state_q;
  assign ip.tx_ready  = ~txvalid_q;
  assign ip.dout      = dout_q;
  assign ip.rx_full   = rx_full_q;
  assign ip.overrun   = overrun_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: bit-bangs a mode-0 SPI master and drives the IP side.
module tb_spi_slave_sync;
  localparam int H = 8;

  logic mclk;
  logic rst;
  logic sclk_in;
  logic cs_n_in;
  logic mosi_in;
  logic miso;
  logic miso_oe;

  int n_cmp  = 0;
  int n_fail = 0;

  spi_slave_sync_if bus ();

  spi_slave_sync #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .mclk    (mclk),
    .rst     (rst),
    .sclk_in (sclk_in),
    .cs_n_in (cs_n_in),
    .mosi_in (mosi_in),
    .miso    (miso),
    .miso_oe (miso_oe),
    .ip      (bus.slave)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge mclk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(2);
  endtask

  task automatic ld_byte(input logic [7:0] v);
    bus.din = v;
    bus.ld  = 1'b1;
    wait_cyc(1);
    bus.ld  = 1'b0;
    wait_cyc(1);
  endtask

  task automatic rd_pulse();
    bus.rd = 1'b1;
    wait_cyc(1);
    bus.rd = 1'b0;
    wait_cyc(1);
  endtask

  task automatic select();
    cs_n_in = 1'b0;
    wait_cyc(H);
  endtask

  task automatic deselect();
    wait_cyc(H);
    cs_n_in = 1'b1;
    mosi_in = 1'b0;
    wait_cyc(H);
  endtask

  // mode 1: check rx_full latency around the last rise; mode 2: rd lands in the completion cycle.
  task automatic spi_xfer(input logic [7:0] tx_b, input int nbits, input int mode,
                          output logic [7:0] rx_b);
    rx_b = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi_in = tx_b[i];
      wait_cyc(H);
      rx_b[i] = miso;
      sclk_in = 1'b1;
      if (i == 0 && mode == 1) begin
        wait_cyc(2);
        check("rx_full_before_lat", bus.rx_full, 8'd0);
        wait_cyc(1);
        check("rx_full_after_lat", bus.rx_full, 8'd1);
        wait_cyc(H - 3);
      end else if (i == 0 && mode == 2) begin
        wait_cyc(2);
        bus.rd = 1'b1;
        wait_cyc(1);
        bus.rd = 1'b0;
        wait_cyc(H - 3);
      end else begin
        wait_cyc(H);
      end
      sclk_in = 1'b0;
    end
  endtask

  logic [7:0] r;

  initial begin
    rst     = 1'b1;
    sclk_in = 1'b0;
    cs_n_in = 1'b1;
    mosi_in = 1'b0;
    bus.din = 8'h00;
    bus.ld  = 1'b0;
    bus.rd  = 1'b0;
    do_reset();

    check("rst_miso", miso, 8'd0);
    check("rst_miso_oe", miso_oe, 8'd0);
    check("rst_tx_ready", bus.tx_ready, 8'd1);
    check("rst_dout", bus.dout, 8'h00);
    check("rst_rx_full", bus.rx_full, 8'd0);
    check("rst_overrun", bus.overrun, 8'd0);
    check("rst_busy", bus.busy, 8'd0);
    check("rst_state", bus.state_dbg, 8'd0);

    // Basic frame: A5 out, 3C in.
    ld_byte(8'hA5);
    check("t1_tx_ready_loaded", bus.tx_ready, 8'd0);
    select();
    check("t1_busy", bus.busy, 8'd1);
    check("t1_miso_oe", miso_oe, 8'd1);
    check("t1_tx_ready_taken", bus.tx_ready, 8'd1);
    spi_xfer(8'h3C, 8, 1, r);
    check("t1_miso_byte", r, 8'hA5);
    check("t1_dout", bus.dout, 8'h3C);
    check("t1_rx_full", bus.rx_full, 8'd1);
    check("t1_tx_ready", bus.tx_ready, 8'd1);
    deselect();
    check("t1_miso_oe_off", miso_oe, 8'd0);
    check("t1_busy_off", bus.busy, 8'd0);
    rd_pulse();
    check("t1_rx_full_rd", bus.rx_full, 8'd0);

    // Back-to-back bytes with a reload and an overrun.
    select();
    ld_byte(8'h81);
    spi_xfer(8'hF0, 8, 0, r);
    check("t2_miso_first", r, 8'h00);
    spi_xfer(8'h0F, 8, 0, r);
    check("t2_miso_second", r, 8'h81);
    check("t2_dout", bus.dout, 8'h0F);
    check("t2_rx_full", bus.rx_full, 8'd1);
    check("t2_overrun", bus.overrun, 8'd1);
    deselect();
    rd_pulse();
    check("t2_rx_full_rd", bus.rx_full, 8'd0);
    check("t2_overrun_rd", bus.overrun, 8'd0);

    // Partial frame is discarded, then a full frame.
    do_reset();
    select();
    spi_xfer(8'hFF, 5, 0, r);
    deselect();
    check("t3_dout_partial", bus.dout, 8'h00);
    check("t3_rx_full_partial", bus.rx_full, 8'd0);
    check("t3_miso_oe_partial", miso_oe, 8'd0);
    select();
    spi_xfer(8'h55, 8, 0, r);
    check("t3_miso_empty", r, 8'h00);
    check("t3_dout", bus.dout, 8'h55);
    check("t3_rx_full", bus.rx_full, 8'd1);
    deselect();
    rd_pulse();

    // ld while the buffer is full is ignored; then rd coinciding with completion.
    ld_byte(8'h11);
    check("t4_tx_ready_full", bus.tx_ready, 8'd0);
    ld_byte(8'h22);
    check("t4_tx_ready_still", bus.tx_ready, 8'd0);
    select();
    spi_xfer(8'h6E, 8, 0, r);
    check("t4_miso_byte", r, 8'h11);
    check("t4_dout", bus.dout, 8'h6E);
    spi_xfer(8'h99, 8, 2, r);
    check("t5_miso_empty", r, 8'h00);
    check("t5_dout", bus.dout, 8'h99);
    check("t5_rx_full", bus.rx_full, 8'd1);
    check("t5_overrun", bus.overrun, 8'd0);
    deselect();

    // Reset in the middle of a frame.
    ld_byte(8'h5A);
    select();
    spi_xfer(8'hF0, 4, 0, r);
    ld_byte(8'h77);
    check("t6_tx_ready_pre", bus.tx_ready, 8'd0);
    check("t6_rx_full_pre", bus.rx_full, 8'd1);
    rst = 1'b1;
    wait_cyc(1);
    check("t6_miso", miso, 8'd0);
    check("t6_miso_oe", miso_oe, 8'd0);
    check("t6_tx_ready", bus.tx_ready, 8'd1);
    check("t6_dout", bus.dout, 8'h00);
    check("t6_rx_full", bus.rx_full, 8'd0);
    check("t6_overrun", bus.overrun, 8'd0);
    check("t6_busy", bus.busy, 8'd0);
    rst = 1'b0;
    deselect();
    select();
    spi_xfer(8'hC3, 8, 0, r);
    check("t6_miso_after", r, 8'h00);
    check("t6_dout_after", bus.dout, 8'hC3);
    check("t6_rx_full_after", bus.rx_full, 8'd1);
    check("t6_overrun_after", bus.overrun, 8'd0);
    deselect();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
